// File: rtl/cbd_sampler.sv
// Centered-binomial sampler: turns a PRF bit stream into one polynomial of N coefficients in [-ETA,ETA].
// Optional macro CBD_SAMPLER_MODQ_EN stores coefficients canonically in [0,3329) instead of two's complement.
module cbd_sampler #(
    parameter int ETA   = 3,
    parameter int DIN_W = 64,
    parameter int N     = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 start_i,
    input  logic [DIN_W-1:0]     din_i,
    input  logic                 din_valid_i,
    output logic                 din_ready_o,
    output logic [N-1:0][11:0]   poly_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int B     = 2 * ETA;
    localparam int BUF_W = DIN_W + B;
    localparam int FW    = $clog2(BUF_W + 1);
    localparam int CW    = $clog2(N);
    localparam int Q     = 3329;

    typedef enum logic [1:0] {IDLE, SAMPLE, DONE} state_t;

    state_t           state;
    logic [BUF_W-1:0] bit_buf;
    logic [BUF_W-1:0] buf_next;
    logic [FW-1:0]    fill;
    logic [FW-1:0]    fill_next;
    logic [CW-1:0]    cnt;
    logic             extract;
    logic             accept;
    logic [11:0]      coef;
    int               pos_sum;
    int               neg_sum;
    int               diff;

    assign busy_o      = (state == SAMPLE);
    assign din_ready_o = busy_o && (fill <= FW'(B));
    assign extract     = busy_o && (fill >= FW'(B));
    // A beat arriving together with start_i is dropped because the buffer restarts empty.
    assign accept      = din_valid_i && din_ready_o && !start_i;

    always_comb begin
        pos_sum = 0;
        neg_sum = 0;
        for (int i = 0; i < ETA; i++) begin
            pos_sum = pos_sum + int'(bit_buf[i]);
            neg_sum = neg_sum + int'(bit_buf[ETA+i]);
        end
        diff = pos_sum - neg_sum;
`ifdef CBD_SAMPLER_MODQ_EN
        if (diff < 0) begin
            diff = diff + Q;
        end
`endif
        coef = 12'(diff);
    end

    // Extraction shifts first, so an append in the same cycle lands at fill - 2*ETA.
    always_comb begin
        buf_next  = bit_buf;
        fill_next = fill;
        if (extract) begin
            buf_next  = bit_buf >> B;
            fill_next = fill - FW'(B);
        end
        if (accept) begin
            buf_next  = buf_next | ({{B{1'b0}}, din_i} << fill_next);
            fill_next = fill_next + FW'(DIN_W);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= IDLE;
            bit_buf <= '0;
            fill    <= '0;
            cnt     <= '0;
            poly_o  <= '0;
            done_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (start_i) begin
                state   <= SAMPLE;
                bit_buf <= '0;
                fill    <= '0;
                cnt     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                    end
                    SAMPLE: begin
                        bit_buf <= buf_next;
                        fill    <= fill_next;
                        if (extract) begin
                            poly_o[cnt] <= coef;
                            cnt         <= cnt + CW'(1);
                            if (cnt == CW'(N - 1)) begin
                                state   <= DONE;
                                done_o  <= 1'b1;
                                bit_buf <= '0;
                                fill    <= '0;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
